// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Architectural flag register, branch-condition evaluator and RUN/HALT FSM
//   sitting directly downstream of the 16-bit ALU.
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   asynchronous, active-high reset
//     aluop       in   opcode of the retiring instruction
//     alu_flag    in   ALU flags, [2]=Z [1]=V [0]=N
//     instr_valid in   retiring instruction is real (not a bubble)
//     stall       in   hold all state this cycle
//     ccc         in   branch condition code
//     br_req      in   current instruction is B or BR
//     flag_q      out  architectural flags {Z,V,N}
//     br_taken    out  branch condition satisfied and branch requested
//     halted      out  FSM is in HALT
//
//   Optional feature macro: FLAG_BYPASS_EN
//     When defined, branch evaluation sees the flags being written in the
//     same cycle (merged next-flag value) instead of only flag_q.

module flag_branch_unit #(
  parameter int unsigned OPW = 4,
  parameter int unsigned FW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] aluop,
  input  logic [FW-1:0]  alu_flag,
  input  logic           instr_valid,
  input  logic           stall,
  input  logic [2:0]     ccc,
  input  logic           br_req,
  output logic [FW-1:0]  flag_q,
  output logic           br_taken,
  output logic           halted
);

  localparam int unsigned ZBit = 2;
  localparam int unsigned VBit = 1;
  localparam int unsigned NBit = 0;

  localparam logic [OPW-1:0] OpAdd = OPW'(0);
  localparam logic [OPW-1:0] OpSub = OPW'(1);
  localparam logic [OPW-1:0] OpXor = OPW'(2);
  localparam logic [OPW-1:0] OpSll = OPW'(4);
  localparam logic [OPW-1:0] OpSra = OPW'(5);
  localparam logic [OPW-1:0] OpRor = OPW'(6);
  localparam logic [OPW-1:0] OpHlt = OPW'(15);

  typedef enum logic {StRun, StHalt} state_e;

  state_e         state_q, state_d;
  logic [FW-1:0]  flag_d;
  logic           run;
  logic           wr;
  logic           wr_z;
  logic           wr_vn;
  logic [FW-1:0]  eff_flag;
  logic           cond;

  // ---------------------------------------------------------------------------
  // State register (FSM + flags)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (state_q == StRun && wr && aluop == OpHlt) begin
      state_d = StHalt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    run    = (state_q == StRun);
    halted = (state_q == StHalt);
  end

  assign wr = instr_valid & ~stall & run;

  // Which flag fields the retiring opcode owns.
  always_comb begin
    wr_z  = 1'b0;
    wr_vn = 1'b0;
    case (aluop)
      OpAdd, OpSub: begin
        wr_z  = 1'b1;
        wr_vn = 1'b1;
      end
      OpXor, OpSll, OpSra, OpRor: begin
        wr_z = 1'b1;
      end
      default: ;
    endcase
  end

  // Unwritten bits come from flag_q so X on unused alu_flag bits never leaks.
  always_comb begin
    flag_d = flag_q;
    if (wr && wr_z) begin
      flag_d[ZBit] = alu_flag[ZBit];
    end
    if (wr && wr_vn) begin
      flag_d[VBit] = alu_flag[VBit];
      flag_d[NBit] = alu_flag[NBit];
    end
  end

`ifdef FLAG_BYPASS_EN
  // flag_d equals flag_q whenever nothing is being written, so it is the
  // merged next-flag value in every case.
  assign eff_flag = flag_d;
`else
  assign eff_flag = flag_q;
`endif

  // ---------------------------------------------------------------------------
  // Branch condition evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    cond = 1'b0;
    unique case (ccc)
      3'b000: cond = ~eff_flag[ZBit];
      3'b001: cond = eff_flag[ZBit];
      3'b010: cond = ~eff_flag[ZBit] & ~eff_flag[NBit];
      3'b011: cond = eff_flag[NBit];
      3'b100: cond = eff_flag[ZBit] | (~eff_flag[ZBit] & ~eff_flag[NBit]);
      3'b101: cond = eff_flag[NBit] | eff_flag[ZBit];
      3'b110: cond = eff_flag[VBit];
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // stall deliberately does not mask br_taken; the PC logic qualifies it.
  assign br_taken = br_req & instr_valid & run & cond;

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] aluop;
  logic [2:0] alu_flag;
  logic       instr_valid;
  logic       stall;
  logic [2:0] ccc;
  logic       br_req;
  logic [2:0] flag_q;
  logic       br_taken;
  logic       halted;

  flag_branch_unit #(
    .OPW (4),
    .FW  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop       (aluop),
    .alu_flag    (alu_flag),
    .instr_valid (instr_valid),
    .stall       (stall),
    .ccc         (ccc),
    .br_req      (br_req),
    .flag_q      (flag_q),
    .br_taken    (br_taken),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] flag;
    logic       taken;
    logic       halted;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] m_flag = 3'b000;
  logic       m_halt = 1'b0;

  // Reference branch conditions on {Z,V,N}.
  function automatic logic cond_f(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'b000: return !z;
      3'b001: return z;
      3'b010: return !z && !n;
      3'b011: return n;
      3'b100: return z || !n;
      3'b101: return n || z;
      3'b110: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Reference flag write rules.
  function automatic logic [2:0] merge_f(input logic [3:0] op, input logic [2:0] af,
                                         input logic [2:0] f);
    case (op)
      4'h0, 4'h1:             return af;
      4'h2, 4'h4, 4'h5, 4'h6: return {af[2], f[1:0]};
      default:                return f;
    endcase
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (flag_q === e.flag) else begin
      errors++;
      $error("FAIL %s.flag_q observed=%b expected=%b", e.tag, flag_q, e.flag);
    end
    checks++;
    assert (br_taken === e.taken) else begin
      errors++;
      $error("FAIL %s.br_taken observed=%b expected=%b", e.tag, br_taken, e.taken);
    end
    checks++;
    assert (halted === e.halted) else begin
      errors++;
      $error("FAIL %s.halted observed=%b expected=%b", e.tag, halted, e.halted);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs 1 ns later, advance model at posedge.
  task automatic step(input string tag, input logic [3:0] op, input logic [2:0] af,
                      input logic v, input logic st, input logic [2:0] c, input logic br,
                      input logic r);
    exp_t       e;
    logic [2:0] f;
    logic       wr;
    @(negedge clk);
    rst         = r;
    aluop       = op;
    alu_flag    = af;
    instr_valid = v;
    stall       = st;
    ccc         = c;
    br_req      = br;
    if (r) begin
      m_flag = 3'b000;
      m_halt = 1'b0;
    end
    wr = v && !st && !m_halt;
    f  = m_flag;
`ifdef FLAG_BYPASS_EN
    if (wr && !r) f = merge_f(op, af, m_flag);
`endif
    e.tag    = tag;
    e.flag   = m_flag;
    e.halted = m_halt;
    e.taken  = br && v && !m_halt && cond_f(c, f);
    sb.push_back(e);
    #1 check_out();
    @(posedge clk);
    if (!r) begin
      if (wr) m_flag = merge_f(op, af, m_flag);
      if (wr && op == 4'hF) m_halt = 1'b1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    aluop       = 4'hC;
    alu_flag    = 3'b000;
    instr_valid = 1'b0;
    stall       = 1'b0;
    ccc         = 3'b000;
    br_req      = 1'b0;

    //   tag           op    af       v     st    ccc     br    rst
    step("rst",        4'hC, 3'b000,  1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
    step("add101",     4'h0, 3'b101,  1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    step("beq",        4'hC, 3'b000,  1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    step("bubble",     4'h0, 3'b010,  1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    step("add111",     4'h0, 3'b111,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    step("xor010",     4'h2, 3'b010,  1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    step("bovf",       4'hC, 3'b000,  1'b1, 1'b0, 3'b110, 1'b1, 1'b0);
    step("sll_x",      4'h4, 3'b1xx,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    step("add000",     4'h0, 3'b000,  1'b1, 1'b0, 3'b101, 1'b1, 1'b0);
    step("paddsb",     4'h7, 3'b111,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    step("bgt",        4'hC, 3'b000,  1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
    step("sub_stall",  4'h1, 3'b001,  1'b1, 1'b1, 3'b011, 1'b1, 1'b0);
    step("sub",        4'h1, 3'b001,  1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
    step("blt",        4'hC, 3'b000,  1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
    step("hlt_stall",  4'hF, 3'b000,  1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    step("hlt",        4'hF, 3'b000,  1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
    step("add_halt",   4'h0, 3'b100,  1'b1, 1'b0, 3'b111, 1'b1, 1'b0);
    step("b_halt",     4'hC, 3'b000,  1'b1, 1'b0, 3'b111, 1'b1, 1'b0);
    step("rst_pulse",  4'hC, 3'b000,  1'b1, 1'b0, 3'b111, 1'b1, 1'b1);
    step("add100",     4'h0, 3'b100,  1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    step("beq2",       4'hC, 3'b000,  1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    step("ble",        4'hC, 3'b000,  1'b1, 1'b0, 3'b101, 1'b1, 1'b0);
    step("bge",        4'hC, 3'b000,  1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
    step("bne",        4'hC, 3'b000,  1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    step("ror_z0",     4'h6, 3'b011,  1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    step("sra_z1",     4'h5, 3'b100,  1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    step("final",      4'hC, 3'b000,  1'b0, 1'b0, 3'b001, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
